// File: rtl/clk_div_bank.sv
// Bank of NCH programmable clock dividers / tick generators sharing one clock.
// Each channel has a registered 50%-duty toggle output, a terminal-count strobe and a shadowed divisor.
module clk_div_bank #(
  parameter int unsigned NCH     = 4,
  parameter int unsigned WIDTH   = 26,
  parameter int unsigned CH_W    = 2,
  parameter int unsigned DIV_RST = 12500000
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic [NCH-1:0]   en,
  input  logic             sync,
  input  logic             wr_en,
  input  logic [CH_W-1:0]  wr_ch,
  input  logic [WIDTH-1:0] wr_div,
  output logic [NCH-1:0]   clk_out,
  output logic [NCH-1:0]   tick,
  output logic [NCH-1:0]   pending
);

  localparam logic [WIDTH-1:0] DIV_RST_W = WIDTH'(DIV_RST);

  logic [WIDTH-1:0] cnt_q     [NCH];
  logic [WIDTH-1:0] cnt_d     [NCH];
  logic [WIDTH-1:0] div_act_q [NCH];
  logic [WIDTH-1:0] div_act_d [NCH];
  logic [WIDTH-1:0] div_new_q [NCH];
  logic [WIDTH-1:0] div_new_d [NCH];
  logic [NCH-1:0]   clk_q, clk_d;
  logic [NCH-1:0]   tick_q, tick_d;
  logic [NCH-1:0]   pend_q, pend_d;
  logic [NCH-1:0]   wr_hit;
  logic [NCH-1:0]   tc;

  // Write decode and terminal-count detect; out-of-range wr_ch matches no channel.
  always_comb begin
    wr_hit = '0;
    tc     = '0;
    for (int i = 0; i < NCH; i++) begin
      wr_hit[i] = wr_en && (wr_ch == CH_W'(i));
      tc[i]     = (cnt_q[i] == div_act_q[i]);
    end
  end

  // Next-state: sync and disable both park the channel and flush any pending divisor.
  always_comb begin
    cnt_d     = cnt_q;
    div_act_d = div_act_q;
    div_new_d = div_new_q;
    clk_d     = clk_q;
    tick_d    = tick_q;
    pend_d    = pend_q;
    for (int i = 0; i < NCH; i++) begin
      if (sync || !en[i]) begin
        cnt_d[i]  = '0;
        clk_d[i]  = 1'b0;
        tick_d[i] = 1'b0;
        pend_d[i] = 1'b0;
        if (wr_hit[i]) begin
          div_act_d[i] = wr_div;
        end else if (pend_q[i]) begin
          div_act_d[i] = div_new_q[i];
        end
      end else begin
        tick_d[i] = tc[i];
        if (tc[i]) begin
          cnt_d[i] = '0;
          clk_d[i] = ~clk_q[i];
          // Handover happens only here, after the compare used the old divisor.
          if (pend_q[i]) begin
            div_act_d[i] = div_new_q[i];
            pend_d[i]    = 1'b0;
          end
        end else begin
          cnt_d[i] = cnt_q[i] + WIDTH'(1);
        end
        if (wr_hit[i]) begin
          div_new_d[i] = wr_div;
          pend_d[i]    = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i]     <= '0;
        div_act_q[i] <= DIV_RST_W;
        div_new_q[i] <= DIV_RST_W;
      end
      clk_q  <= '0;
      tick_q <= '0;
      pend_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      div_act_q <= div_act_d;
      div_new_q <= div_new_d;
      clk_q     <= clk_d;
      tick_q    <= tick_d;
      pend_q    <= pend_d;
    end
  end

  assign clk_out = clk_q;
  assign tick    = tick_q;
  assign pending = pend_q;

endmodule

// File: tb/tb_clk_div_bank.sv
// Bench for clk_div_bank: directed scenarios plus a randomized run, all checked
// every cycle against a behavioural model of the divider rules.
module tb_clk_div_bank;

  localparam int unsigned NCH     = 4;
  localparam int unsigned WIDTH   = 8;
  localparam int unsigned CH_W    = 3;
  localparam int unsigned DIV_RST = 7;

  logic             clk_in = 1'b0;
  logic             rst_n;
  logic [NCH-1:0]   en;
  logic             sync;
  logic             wr_en;
  logic [CH_W-1:0]  wr_ch;
  logic [WIDTH-1:0] wr_div;
  logic [NCH-1:0]   clk_out;
  logic [NCH-1:0]   tick;
  logic [NCH-1:0]   pending;

  int n_vec;
  int n_err;

  // Model: phase counter, divisor in use, shadow divisor (-1 = nothing waiting).
  int m_phase [NCH];
  int m_div   [NCH];
  int m_shadow[NCH];
  bit m_clk   [NCH];
  bit m_tick  [NCH];

  clk_div_bank #(.NCH(NCH), .WIDTH(WIDTH), .CH_W(CH_W), .DIV_RST(DIV_RST)) dut (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .en     (en),
    .sync   (sync),
    .wr_en  (wr_en),
    .wr_ch  (wr_ch),
    .wr_div (wr_div),
    .clk_out(clk_out),
    .tick   (tick),
    .pending(pending)
  );

  always #5 clk_in = ~clk_in;

  function automatic void model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_phase[c]  = 0;
      m_div[c]    = DIV_RST;
      m_shadow[c] = -1;
      m_clk[c]    = 1'b0;
      m_tick[c]   = 1'b0;
    end
  endfunction

  function automatic void model_step();
    for (int c = 0; c < NCH; c++) begin
      bit hit;
      hit = wr_en && (int'(wr_ch) == c);
      if (sync || !en[c]) begin
        if (m_shadow[c] >= 0) m_div[c] = m_shadow[c];
        m_shadow[c] = -1;
        if (hit) m_div[c] = int'(wr_div);
        m_phase[c] = 0;
        m_clk[c]   = 1'b0;
        m_tick[c]  = 1'b0;
      end else begin
        if (m_phase[c] == m_div[c]) begin
          m_tick[c]  = 1'b1;
          m_phase[c] = 0;
          m_clk[c]   = !m_clk[c];
          if (m_shadow[c] >= 0) begin
            m_div[c]    = m_shadow[c];
            m_shadow[c] = -1;
          end
        end else begin
          m_tick[c]  = 1'b0;
          m_phase[c] = m_phase[c] + 1;
        end
        if (hit) m_shadow[c] = int'(wr_div);
      end
    end
  endfunction

  task automatic check_model(input string tag);
    logic [3*NCH-1:0] exp_v;
    for (int c = 0; c < NCH; c++) begin
      exp_v[2*NCH+c] = m_clk[c];
      exp_v[NCH+c]   = m_tick[c];
      exp_v[c]       = (m_shadow[c] >= 0);
    end
    n_vec++;
    if ({clk_out, tick, pending} !== exp_v) begin
      n_err++;
      $display("FAIL %s t=%0t {clk_out,tick,pending}=%b expected %b", tag, $time,
               {clk_out, tick, pending}, exp_v);
    end
  endtask

  task automatic cycle();
    @(posedge clk_in);
    #1;
    if (!rst_n) model_reset();
    else model_step();
    check_model("model");
  endtask

  task automatic write(input int ch, input int d);
    wr_en  = 1'b1;
    wr_ch  = CH_W'(ch);
    wr_div = WIDTH'(d);
    cycle();
    wr_en  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; en = '0; sync = 1'b0; wr_en = 1'b0; wr_ch = '0; wr_div = '0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    n_vec++;
    if ({clk_out, tick, pending} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs got %b expected 0", {clk_out, tick, pending});
    end
    cycle();
    cycle();
    rst_n = 1'b1;
  endtask

  // D=3 loaded while disabled: tick every 4, clk_out period 8.
  task automatic test_basic();
    write(0, 3);
    en[0] = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      cycle();
      n_vec++;
      if (tick[0] !== (k % 4 == 0) || clk_out[0] !== ((k / 4) % 2 == 1) || pending[0] !== 1'b0) begin
        n_err++;
        $display("FAIL basic k=%0d tick=%b clk=%b pend=%b", k, tick[0], clk_out[0], pending[0]);
      end
    end
  endtask

  // Mid-period rewrite 9 -> 1 completes the 10-cycle period first.
  task automatic test_retime();
    write(1, 9);
    en[1] = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      if (k == 5) begin
        wr_en = 1'b1; wr_ch = CH_W'(1); wr_div = WIDTH'(1);
      end
      cycle();
      wr_en = 1'b0;
      n_vec++;
      if (tick[1] !== (k == 10 || k == 12 || k == 14) || pending[1] !== (k >= 5 && k < 10)) begin
        n_err++;
        $display("FAIL retime k=%0d tick=%b pend=%b", k, tick[1], pending[1]);
      end
    end
  endtask

  task automatic test_div0();
    write(2, 0);
    en[2] = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      cycle();
      n_vec++;
      if (tick[2] !== 1'b1 || clk_out[2] !== (k % 2 == 1)) begin
        n_err++;
        $display("FAIL div0 k=%0d tick=%b clk=%b expected tick=1 clk=%0d", k, tick[2], clk_out[2], k % 2);
      end
    end
  endtask

  task automatic test_sync();
    write(3, 5);
    en[3] = 1'b1;
    repeat ($urandom_range(3, 9)) cycle();
    sync = 1'b1;
    cycle();
    sync = 1'b0;
    n_vec++;
    if (clk_out !== '0 || tick !== '0) begin
      n_err++;
      $display("FAIL sync_clear clk_out=%b tick=%b expected 0", clk_out, tick);
    end
    for (int k = 1; k <= 12; k++) begin
      cycle();
      n_vec++;
      if (tick[0] !== (k % 4 == 0) || tick[3] !== (k % 6 == 0)) begin
        n_err++;
        $display("FAIL sync_align k=%0d tick0=%b tick3=%b", k, tick[0], tick[3]);
      end
    end
  endtask

  // Out-of-range write, then a write landing exactly on a terminal count of ch1 (D=1).
  task automatic test_write_edge();
    int w;
    write(5, 2);
    n_vec++;
    if (pending !== '0) begin
      n_err++;
      $display("FAIL bad_ch pending=%b expected 0", pending);
    end
    w = 0;
    while (tick[1] !== 1'b1 && w < 10) begin
      cycle();
      w++;
    end
    n_vec++;
    if (tick[1] !== 1'b1) begin
      n_err++;
      $display("FAIL wait_tick1 tick1=%b expected 1 within 10 cycles", tick[1]);
    end
    write(1, 4);
    write(1, 6);
    n_vec++;
    if (tick[1] !== 1'b1 || pending[1] !== 1'b1) begin
      n_err++;
      $display("FAIL tc_write tick1=%b pend1=%b expected 1 1", tick[1], pending[1]);
    end
    for (int k = 1; k <= 12; k++) begin
      cycle();
      n_vec++;
      if (tick[1] !== (k == 5 || k == 12) || pending[1] !== (k < 5)) begin
        n_err++;
        $display("FAIL tc_commit k=%0d tick1=%b pend1=%b", k, tick[1], pending[1]);
      end
    end
  endtask

  task automatic test_async_reset();
    en = '1;
    repeat (5) cycle();
    @(posedge clk_in);
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    n_vec++;
    if ({clk_out, tick, pending} !== '0) begin
      n_err++;
      $display("FAIL async_reset got %b expected 0", {clk_out, tick, pending});
    end
    cycle();
    cycle();
    rst_n = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      cycle();
      n_vec++;
      if (tick !== ((k == DIV_RST + 1) ? 4'hF : 4'h0)) begin
        n_err++;
        $display("FAIL reset_release k=%0d tick=%b", k, tick);
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 7) == 0) en = NCH'($urandom);
      sync   = ($urandom_range(0, 39) == 0);
      wr_en  = ($urandom_range(0, 3) == 0);
      wr_ch  = CH_W'($urandom_range(0, 7));
      wr_div = WIDTH'($urandom_range(0, 12));
      cycle();
    end
    sync  = 1'b0;
    wr_en = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_basic();
    test_retime();
    test_div0();
    test_sync();
    test_write_edge();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
